// File: rtl/seq_detect_pkg.sv
// Shared definitions for the round-robin scheduled pattern detector:
// one-hot FSM state encodings and width helpers.
package seq_detect_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] IDLE   = 4'b0001;
    localparam logic [ST_W-1:0] LOAD   = 4'b0010;
    localparam logic [ST_W-1:0] SHIFT  = 4'b0100;
    localparam logic [ST_W-1:0] REPORT = 4'b1000;

    // CNT_W: enough bits to hold 0..WORD_W (hit count and bit index).
    function automatic int cnt_w(input int word_w);
        return $clog2(word_w + 1);
    endfunction

    // ID_W: requester index width.
    function automatic int id_w(input int num_req);
        return $clog2(num_req);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial overlapping matcher: PAT_LEN-bit window, fill counter and
// combinational Mealy hit covering the bit currently being shifted in.
module seq_match_core #(
    parameter int PAT_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               hit
);

    localparam int FILL_W = $clog2(PAT_LEN);

    logic [PAT_LEN-2:0] window;
    logic [FILL_W-1:0]  fill;
    logic [PAT_LEN-1:0] window_nxt;

    assign window_nxt = {window, bit_in};

    // fill saturates at PAT_LEN-1: that many older bits plus bit_in make a full window
    assign hit = shift_en && (fill == FILL_W'(PAT_LEN - 1)) && (window_nxt == pattern);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= window_nxt[PAT_LEN-2:0];
            if (fill != FILL_W'(PAT_LEN - 1)) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial pattern detector among NUM_REQ requesters.
// Optional SEQ_DETECT_SCHED_HIT_MASK_EN adds a per-bit hit_mask result output.
//
// state  | meaning
// IDLE   | arbitrate; grant first req at or after rr_ptr
// LOAD   | latch granted word and pattern, clear matcher and counters
// SHIFT  | feed one bit per cycle MSB-first, WORD_W cycles
// REPORT | done pulse; results valid; advance rr_ptr on exit
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8,
    parameter int PAT_LEN = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WORD_W-1:0]   word_in,
    input  logic [PAT_LEN-1:0]          pattern,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic                        done,
    output logic [id_w(NUM_REQ)-1:0]    done_id,
    output logic [cnt_w(WORD_W)-1:0]    hit_cnt
`ifdef SEQ_DETECT_SCHED_HIT_MASK_EN
    ,
    output logic [WORD_W-1:0]           hit_mask
`endif
);

    localparam int CNT_W = cnt_w(WORD_W);
    localparam int ID_W  = id_w(NUM_REQ);

    if (PAT_LEN > WORD_W) begin : g_bad_pat_len
        $error("seq_detect_sched: PAT_LEN must not exceed WORD_W");
    end

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick;
    logic              pick_vld;
    logic [ID_W-1:0]   gnt_idx;
    logic [WORD_W-1:0] word_q;
    logic [PAT_LEN-1:0] pat_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  hit_acc;
    logic              last_bit;
    logic              hit;
    int                idx;

    assign last_bit = (bit_cnt == '0);

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_vld && req[ID_W'(idx)]) begin
                pick_vld = 1'b1;
                pick     = ID_W'(idx);
            end
        end
    end

    seq_match_core #(
        .PAT_LEN (PAT_LEN)
    ) u_match (
        .clk      (clk),
        .reset    (reset),
        .clr      (state == LOAD),
        .shift_en (state == SHIFT),
        .bit_in   (word_q[WORD_W-1]),
        .pattern  (pat_q),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == REPORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt     <= '0;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            done_id <= '0;
            hit_cnt <= '0;
            word_q  <= '0;
            pat_q   <= '0;
            bit_cnt <= '0;
            hit_acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt     <= NUM_REQ'(1) << pick;
                        gnt_idx <= pick;
                    end
                end
                LOAD: begin
                    word_q  <= word_in[gnt_idx*WORD_W +: WORD_W];
                    pat_q   <= pattern;
                    bit_cnt <= CNT_W'(WORD_W - 1);
                    hit_acc <= '0;
                end
                SHIFT: begin
                    word_q  <= word_q << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    hit_acc <= hit_acc + CNT_W'(hit);
                    if (last_bit) begin
                        // include a hit landing on the final bit
                        hit_cnt <= hit_acc + CNT_W'(hit);
                        done_id <= gnt_idx;
                    end
                end
                REPORT: begin
                    gnt    <= '0;
                    rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_DETECT_SCHED_HIT_MASK_EN
    logic [WORD_W-2:0] mask_acc;
    logic [WORD_W-1:0] mask_nxt;

    // shift index 0 ends up in the MSB after WORD_W shifts
    assign mask_nxt = {mask_acc, hit};

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_acc <= '0;
            hit_mask <= '0;
        end else if (state == LOAD) begin
            mask_acc <= '0;
        end else if (state == SHIFT) begin
            mask_acc <= mask_nxt[WORD_W-2:0];
            if (last_bit) begin
                hit_mask <= mask_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: latency, overlap, round-robin order,
// reset abort and input isolation. Checks hit_mask when SEQ_DETECT_SCHED_HIT_MASK_EN is set.
module tb_seq_detect_sched;

    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 8;
    localparam int PAT_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] word_in;
    logic [3:0]  pattern;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  hit_cnt;
`ifdef SEQ_DETECT_SCHED_HIT_MASK_EN
    logic [7:0]  hit_mask;
`endif

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    seq_detect_sched #(
        .NUM_REQ (NUM_REQ),
        .WORD_W  (WORD_W),
        .PAT_LEN (PAT_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .word_in  (word_in),
        .pattern  (pattern),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .hit_cnt  (hit_cnt)
`ifdef SEQ_DETECT_SCHED_HIT_MASK_EN
        ,
        .hit_mask (hit_mask)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_mask(input string tag, input logic [7:0] exp);
`ifdef SEQ_DETECT_SCHED_HIT_MASK_EN
        chk(tag, hit_mask, exp);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic run_one(input int id, input logic [7:0] w, input logic [3:0] pat,
                           input logic [3:0] exp_cnt, input logic [7:0] exp_mask,
                           input string tag);
        word_in[id*8 +: 8] = w;
        pattern = pat;
        req = 4'b0001 << id;
        tick();
        chk({tag, "_gnt"}, gnt, 4'b0001 << id);
        req = 4'b0000;
        wait_done(tag);
        chk({tag, "_cnt"}, hit_cnt, exp_cnt);
        chk({tag, "_id"}, done_id, id);
        chk_mask({tag, "_mask"}, exp_mask);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    logic [3:0] rr_gnt [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] rr_cnt [4]  = '{4'd2, 4'd0, 4'd1, 4'd2};
    logic [7:0] rr_mask [4] = '{8'h12, 8'h00, 8'h01, 8'h11};

    initial begin
        int last_done;
        reset   = 1'b1;
        req     = 4'b0000;
        word_in = 32'h0;
        pattern = 4'b0000;

        do_reset();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_id", done_id, 0);
        chk("rst_cnt", hit_cnt, 0);
        chk_mask("rst_mask", 8'h00);

        // basic job with exact latency from the grant edge
        word_in[7:0] = 8'hB6;
        pattern = 4'b1011;
        req = 4'b0001;
        tick();
        chk("lat_gnt", gnt, 4'b0001);
        chk("lat_busy", busy, 1);
        req = 4'b0000;
        repeat (8) tick();
        chk("lat_e8_done", done, 0);
        chk("lat_e8_busy", busy, 1);
        tick();
        chk("lat_e9_done", done, 1);
        chk("lat_cnt", hit_cnt, 2);
        chk("lat_id", done_id, 0);
        chk_mask("lat_mask", 8'h12);
        tick();
        chk("lat_e10_done", done, 0);
        chk("lat_e10_gnt", gnt, 0);
        chk("lat_e10_busy", busy, 0);
        chk("lat_hold_cnt", hit_cnt, 2);

        run_one(1, 8'hFF, 4'b1111, 4'd5, 8'h1F, "ovl_ff");
        run_one(2, 8'hFF, 4'b1011, 4'd0, 8'h00, "nohit_ff");
        run_one(3, 8'hAA, 4'b1010, 4'd3, 8'h15, "alt_aa");
        run_one(0, 8'h00, 4'b0000, 4'd5, 8'h1F, "zero");
        run_one(1, 8'hB0, 4'b1011, 4'd1, 8'h10, "first_win");
        run_one(2, 8'h0B, 4'b1011, 4'd1, 8'h01, "last_bit");

        // round-robin with all requests held
        do_reset();
        word_in = {8'hBB, 8'h0B, 8'hFF, 8'hB6};
        pattern = 4'b1011;
        req = 4'b1111;
        last_done = 0;
        for (int j = 0; j < 5; j++) begin
            wait_done($sformatf("rr%0d", j));
            chk($sformatf("rr%0d_gnt", j), gnt, rr_gnt[j]);
            chk($sformatf("rr%0d_id", j), done_id, j % 4);
            chk($sformatf("rr%0d_cnt", j), hit_cnt, rr_cnt[j % 4]);
            chk_mask($sformatf("rr%0d_mask", j), rr_mask[j % 4]);
            if (j > 0) chk($sformatf("rr%0d_gap", j), cyc - last_done, 11);
            last_done = cyc;
            if (j == 4) req = 4'b0000;
            tick();
        end

        // reset mid-SHIFT with rr_ptr advanced to 3
        run_one(2, 8'h0B, 4'b1011, 4'd1, 8'h01, "pre_rst");
        req = 4'b0001;
        tick();
        chk("abort_gnt", gnt, 4'b0001);
        req = 4'b0000;
        repeat (4) tick();
        chk("abort_busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_gnt0", gnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", hit_cnt, 0);
        chk("abort_id", done_id, 0);
        chk_mask("abort_mask", 8'h00);
        word_in[15:8] = 8'hB6;
        req = 4'b1010;
        tick();
        chk("post_rst_gnt", gnt, 4'b0010);
        req = 4'b0000;
        wait_done("post_rst");
        chk("post_rst_cnt", hit_cnt, 2);
        chk("post_rst_id", done_id, 1);
        tick();

        // inputs changed and req dropped after LOAD do not disturb the job
        word_in[23:16] = 8'hFF;
        pattern = 4'b1111;
        req = 4'b0100;
        tick();
        chk("iso_gnt", gnt, 4'b0100);
        req = 4'b0000;
        repeat (3) tick();
        word_in[23:16] = 8'h00;
        pattern = 4'b1011;
        wait_done("iso");
        chk("iso_cnt", hit_cnt, 5);
        chk("iso_id", done_id, 2);
        chk_mask("iso_mask", 8'h1F);
        tick();
        chk("iso_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
